// File: rtl/mac_rx_parser.sv
`default_nettype none
// ============================================================================
// mac_rx_parser : strips preamble/SFD, filters on dest MAC and forwards the
// payload with the FCS removed. Optional CRC-32 check: MAC_RX_CRC_CHECK_EN.
// Rev 1.0
// ============================================================================
module mac_rx_parser #(
  parameter int P_MIN_PREAMBLE = 1,
  parameter int P_MAX_LEN      = 1518
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [47:0] i_local_mac,
  input  logic [7:0]  i_GMII_data,
  input  logic        i_GMII_valid,
  output logic [47:0] o_src_mac,
  output logic [15:0] o_type,
  output logic [7:0]  o_data,
  output logic        o_valid,
  output logic        o_last,
  output logic        o_frame_done,
  output logic        o_frame_err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_HDR  = 3'd2,
    S_PAY  = 3'd3,
    S_DROP = 3'd4
  } state_t;

  localparam logic [47:0] C_BCAST   = 48'hFFFF_FFFF_FFFF;
  localparam logic [10:0] C_MAX_CNT = 11'(P_MAX_LEN);

  state_t      state_q, state_d;
  logic [2:0]  pre_cnt_q, pre_cnt_d;
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic [2:0]  pay_cnt_q, pay_cnt_d;
  logic [55:0] hdr_q, hdr_d;
  logic [39:0] dly_q, dly_d;
  logic [47:0] src_mac_q, src_mac_d;
  logic [15:0] type_q, type_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        crc_bad;
  logic [63:0] hdr_shift;
  logic        dest_ok;

  assign hdr_shift = {hdr_q, i_GMII_data};
  assign dest_ok   = (hdr_shift[47:0] == i_local_mac) || (hdr_shift[47:0] == C_BCAST);

`ifdef MAC_RX_CRC_CHECK_EN
  logic [31:0] crc_q, crc_d;

  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++)
      c = (c[0] ^ b[i]) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    return c;
  endfunction

  // Seeded on every preamble byte so it is fresh when the SFD arrives.
  always_comb begin
    crc_d = crc_q;
    if (i_GMII_valid && state_q == S_PRE)
      crc_d = 32'hFFFF_FFFF;
    else if (i_GMII_valid && (state_q == S_HDR || state_q == S_PAY))
      crc_d = crc_byte(crc_q, i_GMII_data);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) crc_q <= '0;
    else          crc_q <= crc_d;
  end

  assign crc_bad = (crc_q != 32'hDEBB_20E3);
`else
  assign crc_bad = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    byte_cnt_d = byte_cnt_q;
    pay_cnt_d  = pay_cnt_q;
    hdr_d      = hdr_q;
    dly_d      = dly_q;
    src_mac_d  = src_mac_q;
    type_d     = type_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    last_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_GMII_valid) begin
          if (i_GMII_data == 8'h55) begin
            pre_cnt_d = 3'd1;
            state_d   = S_PRE;
          end else begin
            state_d = S_DROP;
          end
        end
      end
      S_PRE: begin
        if (!i_GMII_valid) begin
          state_d = S_IDLE;
        end else if (i_GMII_data == 8'h55) begin
          pre_cnt_d = (pre_cnt_q == 3'd7) ? 3'd7 : pre_cnt_q + 3'd1;
        end else if (i_GMII_data == 8'hD5 && int'(pre_cnt_q) >= P_MIN_PREAMBLE) begin
          byte_cnt_d = '0;
          pay_cnt_d  = '0;
          state_d    = S_HDR;
        end else begin
          state_d = S_DROP;
        end
      end
      S_HDR: begin
        if (!i_GMII_valid) begin
          state_d = S_IDLE;
        end else begin
          byte_cnt_d = byte_cnt_q + 11'd1;
          hdr_d      = hdr_shift[55:0];
          if (byte_cnt_q == 11'd5 && !dest_ok) begin
            state_d = S_DROP;
          end else if (byte_cnt_q == 11'd13) begin
            src_mac_d = hdr_shift[63:16];
            type_d    = hdr_shift[15:0];
            state_d   = S_PAY;
          end
        end
      end
      S_PAY: begin
        if (!i_GMII_valid) begin
          // Oldest delay-line byte is the last payload byte; the other four are FCS.
          done_d  = 1'b1;
          state_d = S_IDLE;
          if (pay_cnt_q == 3'd5) begin
            valid_d = 1'b1;
            last_d  = 1'b1;
            data_d  = dly_q[39:32];
            err_d   = crc_bad;
          end else begin
            err_d = 1'b1;
          end
        end else if (byte_cnt_q == C_MAX_CNT) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = S_DROP;
        end else begin
          byte_cnt_d = byte_cnt_q + 11'd1;
          dly_d      = {dly_q[31:0], i_GMII_data};
          if (pay_cnt_q == 3'd5) begin
            valid_d = 1'b1;
            data_d  = dly_q[39:32];
          end else begin
            pay_cnt_d = pay_cnt_q + 3'd1;
          end
        end
      end
      S_DROP: begin
        if (!i_GMII_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      pre_cnt_q  <= '0;
      byte_cnt_q <= '0;
      pay_cnt_q  <= '0;
      hdr_q      <= '0;
      dly_q      <= '0;
      src_mac_q  <= '0;
      type_q     <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      pay_cnt_q  <= pay_cnt_d;
      hdr_q      <= hdr_d;
      dly_q      <= dly_d;
      src_mac_q  <= src_mac_d;
      type_q     <= type_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign o_src_mac    = src_mac_q;
  assign o_type       = type_q;
  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_last       = last_q;
  assign o_frame_done = done_q;
  assign o_frame_err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_rx_parser.sv
`default_nettype none
// ============================================================================
// tb_mac_rx_parser : directed and random frames checked against a frame-level
// reference model. Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_mac_rx_parser;

  localparam int          P_MIN_PREAMBLE = 1;
  localparam int          P_MAX_LEN      = 1518;
  localparam logic [47:0] LOCAL_MAC      = 48'h000A_3501_0203;
  localparam logic [47:0] SRC_MAC        = 48'h0011_2233_4455;
`ifdef MAC_RX_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  gmii_data = '0;
  logic        gmii_valid = 1'b0;
  logic [47:0] o_src_mac;
  logic [15:0] o_type;
  logic [7:0]  o_data;
  logic        o_valid, o_last, o_frame_done, o_frame_err;

  always #5 clk = ~clk;

  mac_rx_parser #(.P_MIN_PREAMBLE(P_MIN_PREAMBLE), .P_MAX_LEN(P_MAX_LEN)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_local_mac(LOCAL_MAC),
    .i_GMII_data(gmii_data), .i_GMII_valid(gmii_valid),
    .o_src_mac(o_src_mac), .o_type(o_type), .o_data(o_data), .o_valid(o_valid),
    .o_last(o_last), .o_frame_done(o_frame_done), .o_frame_err(o_frame_err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor
  logic [7:0]  got_q[$];
  int          last_cnt = 0, last_idx = -1, done_cnt = 0, done_err = 0, done_cyc = -1, stray_err = 0;
  logic [47:0] done_src = '0;
  logic [15:0] done_type = '0;

  always @(negedge clk) begin
    if (o_valid) got_q.push_back(o_data);
    if (o_last) begin
      last_cnt++;
      last_idx = o_valid ? got_q.size() - 1 : -2;
    end
    if (o_frame_done) begin
      done_cnt++;
      done_err  = int'(o_frame_err);
      done_cyc  = cyc;
      done_src  = o_src_mac;
      done_type = o_type;
    end else if (o_frame_err) begin
      stray_err++;
    end
  end

  task automatic mon_clear();
    got_q     = {};
    last_cnt  = 0;
    last_idx  = -1;
    done_cnt  = 0;
    done_err  = 0;
    done_cyc  = -1;
    stray_err = 0;
  endtask

  // Ethernet FCS value (complemented reflected CRC-32) over a byte list
  function automatic logic [31:0] fcs32(input logic [7:0] b[$]);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFF_FFFF;
    foreach (b[i]) begin
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ b[i][k];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB8_8320;
      end
    end
    return ~c;
  endfunction

  task automatic make_frame(input int n_pre, input logic [47:0] dst, input logic [47:0] src,
                            input logic [15:0] ety, input int plen, input bit inc, input int flip,
                            output logic [7:0] fr[$]);
    logic [7:0]  body[$];
    logic [31:0] fcs;
    body = {};
    for (int k = 5; k >= 0; k--) body.push_back(dst[8*k +: 8]);
    for (int k = 5; k >= 0; k--) body.push_back(src[8*k +: 8]);
    body.push_back(ety[15:8]);
    body.push_back(ety[7:0]);
    for (int i = 0; i < plen; i++) body.push_back(inc ? 8'(i) : 8'($urandom));
    fcs = fcs32(body);
    for (int k = 0; k < 4; k++) body.push_back(fcs[8*k +: 8]);
    if (flip >= 0 && flip < plen) body[14 + flip] = body[14 + flip] ^ 8'(1 << $urandom_range(0, 7));
    fr = {};
    for (int i = 0; i < n_pre; i++) fr.push_back(8'h55);
    fr.push_back(8'hD5);
    foreach (body[i]) fr.push_back(body[i]);
  endtask

  // Frame-level reference: what the receiver should report for a whole frame
  task automatic model(input logic [7:0] fr[$], output logic [7:0] eq[$], output int e_done,
                       output int e_err, output int e_last, output logic [47:0] e_src,
                       output logic [15:0] e_type, output int ovr_idx);
    int          np, len;
    logic [7:0]  rest[$];
    logic [7:0]  body[$];
    logic [47:0] dst;
    logic [31:0] rx_fcs;
    eq = {}; e_done = 0; e_err = 0; e_last = 0; e_src = '0; e_type = '0; ovr_idx = -1;
    rest = {}; body = {};
    np = 0;
    while (np < fr.size() && fr[np] == 8'h55) np++;
    if (np < P_MIN_PREAMBLE || np >= fr.size() || fr[np] != 8'hD5) return;
    for (int i = np + 1; i < fr.size(); i++) rest.push_back(fr[i]);
    len = rest.size();
    if (len < 6) return;
    dst = {rest[0], rest[1], rest[2], rest[3], rest[4], rest[5]};
    if (dst != LOCAL_MAC && dst != 48'hFFFF_FFFF_FFFF) return;
    if (len < 14) return;
    e_src  = {rest[6], rest[7], rest[8], rest[9], rest[10], rest[11]};
    e_type = {rest[12], rest[13]};
    e_done = 1;
    if (len > P_MAX_LEN) begin
      // Byte k leaves after byte k+5 arrives; the overrun byte itself emits nothing.
      e_err   = 1;
      ovr_idx = np + 1 + P_MAX_LEN;
      for (int i = 14; i <= P_MAX_LEN - 6; i++) eq.push_back(rest[i]);
      return;
    end
    if (len - 14 < 5) begin
      e_err = 1;
      return;
    end
    for (int i = 0; i < len - 4; i++) body.push_back(rest[i]);
    for (int i = 14; i < len - 4; i++) eq.push_back(rest[i]);
    e_last = 1;
    rx_fcs = {rest[len-1], rest[len-2], rest[len-3], rest[len-4]};
    e_err  = (CRC_EN && fcs32(body) != rx_fcs) ? 1 : 0;
  endtask

  int drv_cyc[$];

  task automatic send(input string tag, input logic [7:0] fr[$], input int gap);
    logic [7:0]  eq[$];
    int          e_done, e_err, e_last, ovr;
    logic [47:0] e_src;
    logic [15:0] e_type;
    drv_cyc = {};
    foreach (fr[i]) begin
      @(posedge clk); #1;
      gmii_data  = fr[i];
      gmii_valid = 1'b1;
      drv_cyc.push_back(cyc);
    end
    @(posedge clk); #1;
    gmii_valid = 1'b0;
    gmii_data  = '0;
    @(posedge clk);
    @(negedge clk); #1;
    model(fr, eq, e_done, e_err, e_last, e_src, e_type, ovr);
    check_eq({tag, "_nvalid"}, 64'(got_q.size()), 64'(eq.size()));
    if (got_q.size() == eq.size())
      foreach (eq[i]) check_eq({tag, "_data"}, 64'(got_q[i]), 64'(eq[i]));
    check_eq({tag, "_done"}, 64'(done_cnt), 64'(e_done));
    check_eq({tag, "_last"}, 64'(last_cnt), 64'(e_last));
    check_eq({tag, "_stray_err"}, 64'(stray_err), 64'd0);
    if (e_last != 0) check_eq({tag, "_last_pos"}, 64'(last_idx), 64'(eq.size() - 1));
    if (e_done != 0) begin
      check_eq({tag, "_err"}, 64'(done_err), 64'(e_err));
      check_eq({tag, "_src"}, 64'(done_src), 64'(e_src));
      check_eq({tag, "_type"}, 64'(done_type), 64'(e_type));
    end
    if (ovr >= 0) check_eq({tag, "_ovr_cyc"}, 64'(done_cyc), 64'(drv_cyc[ovr] + 1));
    mon_clear();
    repeat (gap - 1) @(posedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  fr[$];
    logic [47:0] d;
    int          kind, npre, plen, flip, cut;

    repeat (3) @(negedge clk);
    check_eq("reset_src_type", {o_src_mac, o_type}, 64'd0);
    check_eq("reset_ctl", 64'({o_data, o_valid, o_last, o_frame_done, o_frame_err}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_clear();

    make_frame(7, LOCAL_MAC, SRC_MAC, 16'h0800, 46, 1'b1, -1, fr);
    send("good", fr, 2);
    make_frame(7, LOCAL_MAC, SRC_MAC, 16'h0800, 46, 1'b1, 10, fr);
    send("bitflip", fr, 2);
    make_frame(7, 48'h000A_3501_0204, SRC_MAC, 16'h0800, 46, 1'b1, -1, fr);
    send("wrong_dest", fr, 1);
    make_frame(7, 48'hFFFF_FFFF_FFFF, SRC_MAC, 16'h0806, 46, 1'b1, -1, fr);
    send("bcast", fr, 2);
    make_frame(3, LOCAL_MAC, SRC_MAC, 16'h0800, 46, 1'b1, -1, fr);
    fr[2] = 8'hAA;
    send("bad_pre", fr, 2);
    make_frame(0, LOCAL_MAC, SRC_MAC, 16'h0800, 46, 1'b1, -1, fr);
    send("no_pre", fr, 2);
    make_frame(7, LOCAL_MAC, SRC_MAC, 16'h0800, 3, 1'b1, -1, fr);
    send("runt", fr, 2);
    make_frame(7, LOCAL_MAC, SRC_MAC, 16'h0800, 1, 1'b1, -1, fr);
    send("min_pay", fr, 2);
    make_frame(7, LOCAL_MAC, SRC_MAC, 16'h0800, 1582, 1'b0, -1, fr);
    send("overrun", fr, 2);

    // Reset during the payload of an accepted frame
    make_frame(7, LOCAL_MAC, SRC_MAC, 16'h0800, 46, 1'b1, -1, fr);
    foreach (fr[i]) begin
      @(posedge clk); #1;
      if (i == 40) rst_n = 1'b0;
      if (i == 43) rst_n = 1'b1;
      gmii_data  = fr[i];
      gmii_valid = 1'b1;
      if (i == 40) begin
        @(negedge clk);
        check_eq("midrst_src_type", {o_src_mac, o_type}, 64'd0);
        check_eq("midrst_ctl", 64'({o_data, o_valid, o_last, o_frame_done, o_frame_err}), 64'd0);
        mon_clear();
      end
    end
    @(posedge clk); #1;
    gmii_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check_eq("midrst_tail_valid", 64'(got_q.size()), 64'd0);
    check_eq("midrst_tail_done", 64'(done_cnt), 64'd0);
    mon_clear();
    make_frame(7, LOCAL_MAC, SRC_MAC, 16'h0800, 46, 1'b1, -1, fr);
    send("after_rst", fr, 1);

    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 5);
      npre = $urandom_range(0, 8);
      plen = $urandom_range(0, 40);
      flip = (kind == 3 && plen > 0) ? $urandom_range(0, plen - 1) : -1;
      d    = (kind == 1) ? 48'hFFFF_FFFF_FFFF :
             (kind == 2) ? LOCAL_MAC ^ (48'd1 << $urandom_range(0, 47)) : LOCAL_MAC;
      make_frame(npre, d, {16'($urandom), $urandom}, 16'($urandom), plen, 1'b0, flip, fr);
      if (kind == 4) begin
        cut = npre + 1 + $urandom_range(0, 13);
        while (fr.size() > cut) void'(fr.pop_back());
      end
      if (kind == 5 && npre > 0) fr[$urandom_range(0, npre - 1)] = 8'($urandom);
      send("rand", fr, $urandom_range(1, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
